// File: rtl/uart_pkg.sv
// uart_pkg: shared widths and receiver state encoding for the UART link.
package uart_pkg;
  localparam int MSG_W = 15;
  localparam int FRAME_LEN = MSG_W + 2;
  typedef enum logic [1:0] {WAIT_HIGH, IDLE, DATA, STOP} rx_state_e;
endpackage

// File: rtl/uart_rx_buf.sv
// uart_rx_buf: one-entry valid/ready holding buffer with overrun flag.
module uart_rx_buf #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         overrun_o
);
  logic [W-1:0] data_q, data_d;
  logic valid_q, valid_d, ovr_q, ovr_d, load;
  always_comb begin
    load    = push_i && (!valid_q || ready_i);
    data_d  = load ? data_i : data_q;
    valid_d = load || (valid_q && !ready_i);
    ovr_d   = push_i && valid_q && !ready_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: one-bit-per-cycle UART receiver feeding a one-entry output buffer.
module uart_rx
  import uart_pkg::*;
#(
  parameter int MSG_W = uart_pkg::MSG_W
) (
  input  logic             clk_rx,
  input  logic             rst_rx,
  input  logic             msg_in_rx,
  input  logic             ready_rx,
  output logic [MSG_W-1:0] msg_out_rx,
  output logic             valid_rx,
  output logic             frame_err_rx,
  output logic             overrun_rx
);
  localparam int CW = (MSG_W > 1) ? $clog2(MSG_W) : 1;
  rx_state_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MSG_W-1:0] sh_q, sh_d;
  logic ferr_q, ferr_d, push, last;
  assign last = cnt_q == CW'(MSG_W - 1);
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    ferr_d = 1'b0;
    push   = 1'b0;
    case (st_q)
      WAIT_HIGH: st_d = msg_in_rx ? IDLE : WAIT_HIGH;
      IDLE: begin
        st_d  = msg_in_rx ? IDLE : DATA;
        cnt_d = msg_in_rx ? cnt_q : '0;
      end
      DATA: begin
        sh_d  = {sh_q[MSG_W-2:0], msg_in_rx};
        cnt_d = last ? cnt_q : cnt_q + 1'b1;
        st_d  = last ? STOP : DATA;
      end
      STOP: begin
        // a low stop bit must not be mistaken for the next start bit
        push   = msg_in_rx;
        ferr_d = !msg_in_rx;
        st_d   = msg_in_rx ? IDLE : WAIT_HIGH;
      end
      default: st_d = WAIT_HIGH;
    endcase
  end
  always_ff @(posedge clk_rx) begin
    if (rst_rx) begin
      st_q   <= WAIT_HIGH;
      cnt_q  <= '0;
      sh_q   <= '0;
      ferr_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      ferr_q <= ferr_d;
    end
  end
  assign frame_err_rx = ferr_q;
  uart_rx_buf #(.W(MSG_W)) u_buf (
    .clk      (clk_rx),
    .rst      (rst_rx),
    .push_i   (push),
    .data_i   (sh_q),
    .ready_i  (ready_rx),
    .data_o   (msg_out_rx),
    .valid_o  (valid_rx),
    .overrun_o(overrun_rx)
  );
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scripted line/ready/reset schedule checked against a frame-level buffer model.
module tb_uart_rx;
  import uart_pkg::*;
  logic clk_rx = 1'b0;
  logic rst_rx = 1'b1;
  logic msg_in_rx = 1'b1;
  logic ready_rx = 1'b0;
  logic [MSG_W-1:0] msg_out_rx;
  logic valid_rx, frame_err_rx, overrun_rx;
  int checks = 0;
  int errors = 0;
  bit line_q[$];
  bit rdy_q[$];
  bit rst_q[$];
  int ev_q[$];
  logic [MSG_W-1:0] w_q[$];
  always #5 clk_rx = ~clk_rx;
  uart_rx #(.MSG_W(MSG_W)) dut (
    .clk_rx      (clk_rx),
    .rst_rx      (rst_rx),
    .msg_in_rx   (msg_in_rx),
    .ready_rx    (ready_rx),
    .msg_out_rx  (msg_out_rx),
    .valid_rx    (valid_rx),
    .frame_err_rx(frame_err_rx),
    .overrun_rx  (overrun_rx)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit rv(int rm);
    return (rm == 2) ? 1'($urandom_range(1)) : rm[0];
  endfunction
  // ev: 1 = good frame completes this cycle, 2 = bad stop bit this cycle
  task automatic put(bit l, int rm, bit r = 1'b0, int ev = 0, logic [MSG_W-1:0] w = '0);
    line_q.push_back(l);
    rdy_q.push_back(rv(rm));
    rst_q.push_back(r);
    ev_q.push_back(ev);
    w_q.push_back(w);
  endtask
  task automatic idle(int n, int rm);
    repeat (n) put(1'b1, rm);
  endtask
  task automatic frame(logic [MSG_W-1:0] w, bit stop, int rm);
    put(1'b0, rm);
    for (int i = MSG_W - 1; i >= 0; i--) put(w[i], rm);
    put(stop, rm, 1'b0, stop ? 1 : 2, w);
  endtask
  initial begin
    bit mv, mf, mo;
    logic [MSG_W-1:0] mw, rw;
    int exp_ovr, exp_ferr, exp_del, got_ovr, got_ferr, got_del;
    mv = 0; mf = 0; mo = 0; mw = '0;
    exp_ovr = 0; exp_ferr = 0; exp_del = 0; got_ovr = 0; got_ferr = 0; got_del = 0;
    put(1'b1, 1, 1'b1); put(1'b1, 1, 1'b1);
    idle(3, 1);
    frame(15'h2B6D, 1'b1, 1); idle(2, 1);
    frame(15'h7FFF, 1'b1, 1); frame(15'h0001, 1'b1, 1); idle(2, 1);
    frame(15'h1234, 1'b0, 1);
    repeat (5) put(1'b0, 1);
    put(1'b1, 1);
    frame(15'h0F0F, 1'b1, 1); idle(2, 1);
    frame(15'h1111, 1'b1, 0); frame(15'h2222, 1'b1, 0); idle(3, 0);
    put(1'b1, 1); idle(2, 0);
    frame(15'h4444, 1'b1, 0); frame(15'h3333, 1'b1, 0);
    rdy_q[rdy_q.size() - 1] = 1'b1;
    idle(2, 0); idle(2, 1);
    put(1'b0, 1);
    for (int i = MSG_W - 1; i > MSG_W - 8; i--) put(1'($urandom_range(1)), 1);
    put(1'b1, 1, 1'b1); put(1'b1, 1, 1'b1);
    idle(2, 1);
    frame(15'h5555, 1'b1, 1); idle(2, 1);
    repeat (40) begin
      idle($urandom_range(3), 2);
      rw = MSG_W'($urandom);
      if ($urandom_range(7) == 0) begin
        frame(rw, 1'b0, 2);
        repeat ($urandom_range(4)) put(1'b0, 2);
        put(1'b1, 2);
      end else frame(rw, 1'b1, 2);
    end
    idle(4, 1);
    for (int k = 0; k < line_q.size(); k++) begin
      @(negedge clk_rx);
      msg_in_rx = line_q[k];
      ready_rx = rdy_q[k];
      rst_rx = rst_q[k];
      @(posedge clk_rx);
      #1;
      if (rst_q[k]) begin
        mv = 0; mw = '0; mf = 0; mo = 0;
      end else begin
        mf = ev_q[k] == 2;
        mo = 0;
        if (ev_q[k] == 1) begin
          if (!mv || rdy_q[k]) begin
            mv = 1; mw = w_q[k]; exp_del++;
          end else mo = 1;
        end else if (mv && rdy_q[k]) mv = 0;
      end
      exp_ovr += int'(mo);
      exp_ferr += int'(mf);
      got_ovr += int'(overrun_rx);
      got_ferr += int'(frame_err_rx);
      chk("valid_rx", 32'(valid_rx), 32'(mv));
      chk("frame_err_rx", 32'(frame_err_rx), 32'(mf));
      chk("overrun_rx", 32'(overrun_rx), 32'(mo));
      if (mv || rst_q[k]) chk("msg_out_rx", 32'(msg_out_rx), 32'(mw));
      if (valid_rx && (k + 1 < line_q.size()) && rdy_q[k + 1] && !rst_q[k + 1]) got_del++;
    end
    chk("overrun_total", got_ovr, exp_ovr);
    chk("frame_err_total", got_ferr, exp_ferr);
    chk("frame_len", 32'(FRAME_LEN), 32'(MSG_W + 2));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter MSG_W, default 15: codeword width carried per frame.
REQ-002 Port clk_rx, input, 1: single clock; all state updates on rising edge.
REQ-003 Port rst_rx, input, 1: reset, synchronous, active-high.
REQ-004 Port msg_in_rx, input, 1: serial line, idle high, one bit per clk_rx cycle, same clock domain as the transmitter (no synchronizer).
REQ-005 Port msg_out_rx, output, MSG_W: received codeword to the Hamming decoder, held stable while valid_rx=1.
REQ-006 Port valid_rx, output, 1: msg_out_rx holds an unconsumed codeword.
REQ-007 Port ready_rx, input, 1: decoder accepts msg_out_rx when valid_rx&ready_rx.
REQ-008 Port frame_err_rx, output, 1: one-cycle pulse, stop bit sampled 0.
REQ-009 Port overrun_rx, output, 1: one-cycle pulse, good frame dropped because the buffer was full.

Function
REQ-010 Frame SHALL be 17 cycles: start bit 0, MSG_W data bits MSB first (bit 14 first), stop bit 1; no baud divider, every cycle samples one bit.
REQ-011 FSM states SHALL be WAIT_HIGH, IDLE, DATA, STOP.
REQ-012 WAIT_HIGH: stay while msg_in_rx=0; go to IDLE on the first sample of 1.
REQ-013 IDLE: msg_in_rx=0 -> DATA with bit counter cleared; msg_in_rx=1 -> stay.
REQ-014 DATA: shift msg_in_rx into the LSB of the shift register each cycle; after the MSG_W-th bit -> STOP; counter width ceil(log2(MSG_W)), no wrap beyond MSG_W-1.
REQ-015 STOP with msg_in_rx=1: frame good, deliver the shift register to the buffer, -> IDLE.
REQ-016 STOP with msg_in_rx=0: frame_err_rx=1 the next cycle, data discarded, -> WAIT_HIGH (the low stop bit is never taken as a start bit).
REQ-017 Back-to-back frames with zero idle cycles SHALL be received: the cycle after STOP, IDLE samples the next start bit.
REQ-018 Delivery latency: valid_rx rises in the cycle after the stop-bit sample, i.e. 17 cycles after the start-bit sample.
REQ-019 Handshake: valid_rx stays 1 and msg_out_rx is unchanged until a cycle with ready_rx=1; valid_rx falls the following cycle unless REQ-020 applies.
REQ-020 Good frame arriving in the same cycle that valid_rx&ready_rx: the old word is consumed, the new word is loaded, valid_rx stays 1, no overrun.
REQ-021 Good frame arriving while valid_rx=1 and ready_rx=0: the new word is dropped, the old word is kept, and overrun_rx=1 for one cycle.
REQ-022 A framing error never changes msg_out_rx or valid_rx.
REQ-023 ready_rx while valid_rx=0 SHALL have no effect.

Reset
REQ-024 On rst_rx=1 at a clock edge: state=WAIT_HIGH, msg_out_rx=0, shift register=0, counter=0, valid_rx=0, frame_err_rx=0, overrun_rx=0.
REQ-025 Reset mid-frame SHALL discard the partial frame without pulsing frame_err_rx or overrun_rx.

Structure
REQ-026 Shared package uart_pkg SHALL hold MSG_W=15, FRAME_LEN=17 and the rx state enumeration.
REQ-027 The one-entry output buffer with its valid/ready/overrun logic SHALL be a sub-module, uart_rx_buf; the FSM and shifter stay in uart_rx.

Verification
REQ-028 Reset, line held 1, frame for 15'h2B6D (0,bits,1) -> valid_rx at cycle 17 after start, msg_out_rx=15'h2B6D, frame_err_rx=0.
REQ-029 Two back-to-back frames 15'h7FFF then 15'h0001 with ready_rx=1 -> two valid handshakes 17 cycles apart, correct words, no overrun.
REQ-030 Frame 15'h1234 with stop bit 0, line then held 0 for 5 cycles, then 1, then frame 15'h0F0F -> one frame_err_rx pulse, no false start, next word 15'h0F0F.
REQ-031 ready_rx=0, frames 15'h1111 then 15'h2222 -> overrun_rx pulses once, msg_out_rx stays 15'h1111; ready_rx=1 -> valid_rx falls.
REQ-032 ready_rx asserted exactly at the stop-bit cycle of 15'h3333 while holding 15'h4444 -> 15'h4444 consumed, valid_rx stays 1 with 15'h3333, overrun_rx=0.
REQ-033 rst_rx asserted at data bit 7, then a full frame 15'h5555 -> no pulses during reset, valid only for 15'h5555.
